// File: rtl/cond_exec_stage.sv
// cond_exec_stage: decode-to-execute pipeline register and conditional-execution unit.
//
// Captures the decoder control word and condition field into the E register, holds the
// architectural NZCV flags, evaluates the ARM condition of the instruction in E against
// them and gates that instruction's write, branch and link enables.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   StallE, FlushE          hold / bubble the E register (flush wins)
//   CondD, FlagWriteD       condition field and flag-update mask from decode
//   *D controls             decoder control bits, registered into E
//   ALUFlags                {N,Z,C,V} produced by the ALU for the instruction in E
//   ALUControlE, ALUSrcE,
//   MemtoRegE, MovE         registered controls, not condition-gated
//   RegWriteCE, MemWriteCE,
//   BranchTakenE, LinkCE    registered enables gated by CondExE
//   CondExE                 instruction in E is valid and its condition holds
//   Flags                   architectural {N,Z,C,V}
//   CondFailCount           saturating count of valid instructions whose condition failed
module cond_exec_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondD,
    input  logic [1:0]       FlagWriteD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             MemtoRegD,
    input  logic             ALUSrcD,
    input  logic             BranchD,
    input  logic             LinkD,
    input  logic             MovD,
    input  logic [2:0]       ALUControlD,
    input  logic [3:0]       ALUFlags,
    output logic [2:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic             MemtoRegE,
    output logic             MovE,
    output logic             RegWriteCE,
    output logic             MemWriteCE,
    output logic             BranchTakenE,
    output logic             LinkCE,
    output logic             CondExE,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] CondFailCount
);

    // E register
    logic [3:0] cond_q;
    logic [1:0] flagwrite_q;
    logic       regwrite_q, memwrite_q, memtoreg_q, alusrc_q;
    logic       branch_q, link_q, mov_q, valid_q;
    logic [2:0] alucontrol_q;

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] cnt_q;

    logic n, z, c, v;
    logic cond_true;
    logic condex;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_q       <= '0;
            flagwrite_q  <= '0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            alusrc_q     <= 1'b0;
            branch_q     <= 1'b0;
            link_q       <= 1'b0;
            mov_q        <= 1'b0;
            alucontrol_q <= '0;
            valid_q      <= 1'b0;
        end else if (FlushE) begin
            cond_q       <= '0;
            flagwrite_q  <= '0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            alusrc_q     <= 1'b0;
            branch_q     <= 1'b0;
            link_q       <= 1'b0;
            mov_q        <= 1'b0;
            alucontrol_q <= '0;
            valid_q      <= 1'b0;
        end else if (!StallE) begin
            cond_q       <= CondD;
            flagwrite_q  <= FlagWriteD;
            regwrite_q   <= RegWriteD;
            memwrite_q   <= MemWriteD;
            memtoreg_q   <= MemtoRegD;
            alusrc_q     <= ALUSrcD;
            branch_q     <= BranchD;
            link_q       <= LinkD;
            mov_q        <= MovD;
            alucontrol_q <= ALUControlD;
            valid_q      <= 1'b1;
        end
    end

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_true = 1'b1;
        case (cond_q)
            4'b0000: cond_true = z;
            4'b0001: cond_true = ~z;
            4'b0010: cond_true = c;
            4'b0011: cond_true = ~c;
            4'b0100: cond_true = n;
            4'b0101: cond_true = ~n;
            4'b0110: cond_true = v;
            4'b0111: cond_true = ~v;
            4'b1000: cond_true = c & ~z;
            4'b1001: cond_true = ~c | z;
            4'b1010: cond_true = (n == v);
            4'b1011: cond_true = (n != v);
            4'b1100: cond_true = ~z & (n == v);
            4'b1101: cond_true = z | (n != v);
            default: cond_true = 1'b1;
        endcase
    end

    assign condex = valid_q & cond_true;

    // Flag writes depend only on the instruction currently in E; a concurrent flush
    // bubbles the next slot but does not cancel this commit. A stall defers it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            if (condex && flagwrite_q[1] && !StallE) flags_q[3:2] <= ALUFlags[3:2];
            if (condex && flagwrite_q[0] && !StallE) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (valid_q && !cond_true && !StallE && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ALUControlE   = alucontrol_q;
    assign ALUSrcE       = alusrc_q;
    assign MemtoRegE     = memtoreg_q;
    assign MovE          = mov_q;
    assign RegWriteCE    = regwrite_q & condex;
    assign MemWriteCE    = memwrite_q & condex;
    assign BranchTakenE  = branch_q & condex;
    assign LinkCE        = link_q & condex;
    assign CondExE       = condex;
    assign Flags         = flags_q;
    assign CondFailCount = cnt_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage, built with a 2-bit fail counter so saturation is reachable.
module tb_cond_exec_stage;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             StallE = 1'b0;
    logic             FlushE = 1'b0;
    logic [3:0]       CondD = 4'b1110;
    logic [1:0]       FlagWriteD = 2'b00;
    logic             RegWriteD = 1'b0, MemWriteD = 1'b0, MemtoRegD = 1'b0, ALUSrcD = 1'b0;
    logic             BranchD = 1'b0, LinkD = 1'b0, MovD = 1'b0;
    logic [2:0]       ALUControlD = 3'b000;
    logic [3:0]       ALUFlags = 4'b0000;
    logic [2:0]       ALUControlE;
    logic             ALUSrcE, MemtoRegE, MovE;
    logic             RegWriteCE, MemWriteCE, BranchTakenE, LinkCE, CondExE;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] CondFailCount;

    logic [10:0] e_outs;
    assign e_outs = {ALUControlE, ALUSrcE, MemtoRegE, MovE,
                     RegWriteCE, MemWriteCE, BranchTakenE, LinkCE, CondExE};

    typedef struct {
        string      name;
        logic [4:0] gated;  // {RegWriteCE, MemWriteCE, BranchTakenE, LinkCE, CondExE}
        logic [5:0] plain;  // {ALUControlE, ALUSrcE, MemtoRegE, MovE}
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    cond_exec_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .CondD        (CondD),
        .FlagWriteD   (FlagWriteD),
        .RegWriteD    (RegWriteD),
        .MemWriteD    (MemWriteD),
        .MemtoRegD    (MemtoRegD),
        .ALUSrcD      (ALUSrcD),
        .BranchD      (BranchD),
        .LinkD        (LinkD),
        .MovD         (MovD),
        .ALUControlD  (ALUControlD),
        .ALUFlags     (ALUFlags),
        .ALUControlE  (ALUControlE),
        .ALUSrcE      (ALUSrcE),
        .MemtoRegE    (MemtoRegE),
        .MovE         (MovE),
        .RegWriteCE   (RegWriteCE),
        .MemWriteCE   (MemWriteCE),
        .BranchTakenE (BranchTakenE),
        .LinkCE       (LinkCE),
        .CondExE      (CondExE),
        .Flags        (Flags),
        .CondFailCount(CondFailCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle slot: an always-executed instruction with no side effects.
    task automatic set_idle();
        CondD = 4'b1110;
        FlagWriteD = 2'b00;
        {RegWriteD, MemWriteD, BranchD, LinkD} = 4'b0000;
        {ALUControlD, ALUSrcD, MemtoRegD, MovD} = 6'b000000;
    endtask

    task automatic do_reset();
        #2;
        StallE = 1'b0;
        FlushE = 1'b0;
        ALUFlags = 4'b0000;
        set_idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // Drive one instruction, capture it, compare the E outputs and then present the
    // ALU flags it produces. ctl = {RegWrite, MemWrite, Branch, Link};
    // misc = {ALUControl, ALUSrc, MemtoReg, Mov}.
    task automatic issue(input string nm, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] ctl, input logic [5:0] misc,
                         input logic [3:0] alu, input logic pass);
        exp_t e;
        CondD = c;
        FlagWriteD = fw;
        {RegWriteD, MemWriteD, BranchD, LinkD} = ctl;
        {ALUControlD, ALUSrcD, MemtoRegD, MovD} = misc;
        e.name = nm;
        e.gated = pass ? {ctl, 1'b1} : 5'b00000;
        e.plain = misc;
        sb.push_back(e);
        step();
        e = sb.pop_front();
        vectors++;
        if ({RegWriteCE, MemWriteCE, BranchTakenE, LinkCE, CondExE} !== e.gated) begin
            miscompares++;
            $display("FAIL %s gated: got %b want %b", e.name,
                     {RegWriteCE, MemWriteCE, BranchTakenE, LinkCE, CondExE}, e.gated);
        end
        vectors++;
        if ({ALUControlE, ALUSrcE, MemtoRegE, MovE} !== e.plain) begin
            miscompares++;
            $display("FAIL %s plain: got %b want %b", e.name,
                     {ALUControlE, ALUSrcE, MemtoRegE, MovE}, e.plain);
        end
        ALUFlags = alu;
        set_idle();
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({e_outs, Flags, CondFailCount} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0", {e_outs, Flags, CondFailCount});
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (CondExE !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_load: got %b want 1", CondExE);
        end
    endtask

    task automatic test_subs();
        issue("subs", 4'b1110, 2'b11, 4'b1000, 6'b001010, 4'b0100, 1'b1);
        step();
        vectors++;
        if (Flags !== 4'b0100) begin
            miscompares++;
            $display("FAIL subs_flags: got %b want 0100", Flags);
        end
    endtask

    task automatic test_eq_ne();
        issue("eq", 4'b0000, 2'b00, 4'b1100, 6'b101101, 4'b0000, 1'b1);
        vectors++;
        if (CondFailCount !== 2'd0) begin
            miscompares++;
            $display("FAIL eq_count: got %0d want 0", CondFailCount);
        end
        issue("ne", 4'b0001, 2'b00, 4'b1100, 6'b010010, 4'b0000, 1'b0);
        step();
        vectors++;
        if (CondFailCount !== 2'd1) begin
            miscompares++;
            $display("FAIL ne_count: got %0d want 1", CondFailCount);
        end
    endtask

    task automatic test_cond_flag_write();
        do_reset();
        issue("eq_fw", 4'b0000, 2'b11, 4'b1000, 6'b000000, 4'b1111, 1'b0);
        step();
        vectors++;
        if ({Flags, CondFailCount} !== {4'b0000, 2'd1}) begin
            miscompares++;
            $display("FAIL cond_fw: got flags %b count %0d want 0000/1", Flags, CondFailCount);
        end
    endtask

    task automatic test_signed();
        do_reset();
        issue("set_n", 4'b1110, 2'b11, 4'b0000, 6'b000000, 4'b1000, 1'b1);
        issue("ge", 4'b1010, 2'b00, 4'b0010, 6'b000000, 4'b0000, 1'b0);
        issue("lt", 4'b1011, 2'b00, 4'b0011, 6'b000000, 4'b0000, 1'b1);
        issue("gt", 4'b1100, 2'b00, 4'b0010, 6'b000000, 4'b0000, 1'b0);
        issue("le", 4'b1101, 2'b00, 4'b0010, 6'b000000, 4'b0000, 1'b1);
        step();
        vectors++;
        if ({Flags, CondFailCount} !== {4'b1000, 2'd2}) begin
            miscompares++;
            $display("FAIL signed_end: got flags %b count %0d want 1000/2", Flags, CondFailCount);
        end
    endtask

    task automatic test_stall();
        do_reset();
        issue("stall_fw", 4'b1110, 2'b10, 4'b1000, 6'b000000, 4'b1111, 1'b1);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({Flags, RegWriteCE, CondExE} !== {4'b0000, 2'b11}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got %b want 000011", i,
                         {Flags, RegWriteCE, CondExE});
            end
        end
        StallE = 1'b0;
        step();
        vectors++;
        if (Flags !== 4'b1100) begin
            miscompares++;
            $display("FAIL stall_release_flags: got %b want 1100", Flags);
        end
        // Z=1 now, so NE fails; the failure must be counted once, at release.
        issue("stall_ne", 4'b0001, 2'b00, 4'b1000, 6'b000000, 4'b0000, 1'b0);
        StallE = 1'b1;
        step();
        step();
        vectors++;
        if (CondFailCount !== 2'd0) begin
            miscompares++;
            $display("FAIL stall_count_hold: got %0d want 0", CondFailCount);
        end
        StallE = 1'b0;
        step();
        step();
        vectors++;
        if (CondFailCount !== 2'd1) begin
            miscompares++;
            $display("FAIL stall_count_once: got %0d want 1", CondFailCount);
        end
    endtask

    task automatic test_flush();
        issue("fw_flush", 4'b1110, 2'b11, 4'b1000, 6'b111111, 4'b0011, 1'b1);
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        vectors++;
        if ({e_outs, Flags} !== {11'd0, 4'b0011}) begin
            miscompares++;
            $display("FAIL flush_alone: got outs %b flags %b want 0/0011", e_outs, Flags);
        end
        issue("fl_st", 4'b1110, 2'b00, 4'b1111, 6'b111111, 4'b0000, 1'b1);
        FlushE = 1'b1;
        StallE = 1'b1;
        step();
        FlushE = 1'b0;
        StallE = 1'b0;
        vectors++;
        if ({e_outs, CondFailCount} !== {11'd0, 2'd1}) begin
            miscompares++;
            $display("FAIL flush_and_stall: got outs %b count %0d want 0/1", e_outs, CondFailCount);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue("sat", 4'b0000, 2'b00, 4'b1000, 6'b000000, 4'b0000, 1'b0);
            vectors++;
            if (CondFailCount !== 2'((i > 3) ? 3 : i)) begin
                miscompares++;
                $display("FAIL sat_count[%0d]: got %0d want %0d", i, CondFailCount,
                         (i > 3) ? 3 : i);
            end
        end
        step();
        vectors++;
        if (CondFailCount !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_final: got %0d want 3", CondFailCount);
        end
    endtask

    task automatic test_async_reset();
        issue("pre_flags", 4'b1110, 2'b11, 4'b0000, 6'b000000, 4'b1010, 1'b1);
        issue("pre_rst", 4'b1110, 2'b11, 4'b1111, 6'b111111, 4'b0101, 1'b1);
        StallE = 1'b1;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({e_outs, Flags, CondFailCount} !== 17'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 0", {e_outs, Flags, CondFailCount});
        end
        StallE = 1'b0;
        ALUFlags = 4'b0000;
        #1;
        reset_n = 1'b1;
        step();
        vectors++;
        if ({CondExE, Flags} !== {1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL after_reset: got %b want 10000", {CondExE, Flags});
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_subs();
        test_eq_ne();
        test_cond_flag_write();
        test_signed();
        test_stall();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Decode-to-execute pipeline register and conditional-execution unit of the pipelined ARM core. Captures the decoder's control word and condition field each cycle, holds the architectural NZCV flag register, evaluates the 4-bit ARM condition against it, and emits the gated execute-stage write, branch and link enables. It sits directly downstream of the decoder and upstream of the ALU/memory stages. The ALU feeds its flags back into this block.

## Interface
- CNT_W, 16, width of the condition-failed event counter

- clk  in  1  core clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- StallE  in  1  hold E register contents
- FlushE  in  1  load a bubble into E register; wins over StallE
- CondD  in  4  instruction condition field [31:28]
- FlagWriteD  in  2  [1]=update N,Z; [0]=update C,V
- RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD, LinkD, MovD  in  1 each  decoder controls
- ALUControlD  in  3  ALU operation
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the instruction currently in E
- ALUControlE  out  3  registered ALUControlD
- ALUSrcE, MemtoRegE, MovE  out  1 each  registered controls (not condition-gated)
- RegWriteCE, MemWriteCE  out  1 each  registered write enables AND CondExE
- BranchTakenE  out  1  registered BranchD AND CondExE
- LinkCE  out  1  registered LinkD AND CondExE
- CondExE  out  1  ValidE AND condition true
- Flags  out  4  architectural {N,Z,C,V}
- CondFailCount  out  CNT_W  valid instructions whose condition failed

## Operation
- E register fields: Cond, FlagWrite, all D controls, ValidE.
- Each rising edge, with priority:
  - FlushE=1: every E field is cleared to 0, including ValidE.
  - Else StallE=1: every field holds.
  - Else: load the D inputs and set ValidE=1.
- Condition evaluation is combinational on CondE and the current Flags:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 1
- CondExE = ValidE & condition.
- All gated outputs are 0 when CondExE=0.
- Flag register update at the edge:
  - If CondExE & FlagWriteE[1] & !StallE: Flags[3:2] <= ALUFlags[3:2].
  - If CondExE & FlagWriteE[0] & !StallE: Flags[1:0] <= ALUFlags[1:0].
  - Otherwise the bits hold.
- An instruction's condition is always evaluated against flags written by earlier instructions, never its own ALUFlags.
- CondFailCount increments by 1 at the edge when ValidE & !condition & !StallE. It saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Latency: D inputs appear on the E outputs 1 cycle after capture.
- Flags written by the instruction in E at cycle t are visible to the instruction in E at t+1. No flag forwarding is required.
- A stalled E instruction is evaluated exactly once: no flag write and no count while StallE=1, and it commits on the first non-stall edge.
- A FlushE arriving in the same cycle as a flag-setting instruction in E does not cancel that instruction's flag write. The write is gated by the current CondExE, not by FlushE.
- Reset (asynchronous, any time, including mid-stall):
  - All E fields and ValidE = 0.
  - Flags = 4'b0000.
  - CondFailCount = 0.
  - Hence all outputs = 0, with CondExE=0.
- Reset release: the first edge with reset_n=1 loads normally.

## Test plan
- Reset, then a SUBS-like instruction (CondD=1110, FlagWriteD=11, RegWriteD=1) with ALUFlags=0100:
  - Next cycle: RegWriteCE=1, CondExE=1.
  - Following cycle: Flags=0100.
- Flags=0100, then back-to-back CondD=0000 (EQ) and 0001 (NE), each with RegWriteD=1 and MemWriteD=1:
  - EQ gives RegWriteCE=MemWriteCE=1.
  - NE gives both 0, and CondFailCount goes 0→1.
- Conditional flag write: Flags=0000, CondD=0000, FlagWriteD=11, ALUFlags=1111 → Flags stays 0000 and the count increments.
- Signed compares with Flags N=1,V=0,Z=0:
  - GE (1010) fails, LT (1011) passes, GT (1100) fails, LE (1101) passes.
  - With BranchD=1, BranchTakenE follows the pass/fail result.
- Stall then flush:
  - Instruction with FlagWriteD=10 held 3 cycles by StallE=1: Flags unchanged throughout and written once after release.
  - FlushE=1 alone: next cycle ValidE=0 and all gated outputs 0. FlushE and StallE both 1 also flushes.
- Saturation and reset:
  - CNT_W=2 with 5 failing instructions → CondFailCount=3.
  - Assert reset_n=0 mid-sequence (not on a clock edge) → all outputs 0 immediately.
